model_matrix_sequencer: RTL and testbench
=========================================

Name: model_matrix_sequencer

Overview:
Per-frame controller for the model-matrix datapath (`get_model_matrix`). On each frame start it:
- advances the rotation angle by a programmable step and wraps it to [-pi, pi);
- latches scale/translation configuration and drives the matrix generator;
- waits a fixed settle time, snapshots the 4x4 result, and streams the 16 Q8.8 entries row-major to the downstream MVP multiply stage over a valid/ready handshake.

Parameters:
- SETTLE_CYCLES, 3, cycles to wait after driving the generator inputs before snapshotting its combinational output (1..15).
- PI_Q8, 13'h0324, pi in signed Q5.8.
- TWO_PI_Q8, 13'h0648, 2*pi in signed Q5.8.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_start  in  1  single-cycle pulse requesting a new model matrix
- pause  in  1  when 1, angle is not advanced on frame start; matrix is still regenerated and streamed
- angle_step  in  13  signed Q5.8 angle increment per frame
- cfg_scale, cfg_x, cfg_y, cfg_z  in  16 each  Q8.8 configuration values, sampled in UPD
- gen_angle  out  13  angle driven to the generator
- gen_scale, gen_x, gen_y, gen_z  out  16 each  latched configuration driven to the generator
- gen_matrix  in  [15:0][15:0]  generator result; entry k = row k/4, column k%4
- m_valid  out  1  stream entry valid
- m_ready  in  1  downstream accept
- m_data  out  16  current matrix entry
- m_index  out  4  index of the current entry (0..15)
- m_last  out  1  high with entry 15
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse after entry 15 is accepted
- overrun  out  1  sticky flag: a frame_start arrived while one request was already pending

Behaviour:
- Reset values:
  - State IDLE; gen_angle=0; gen_scale=16'h0100; gen_x/y/z=0.
  - m_valid=0, m_index=0, m_data=0, m_last=0, busy=0, frame_done=0, overrun=0, pending=0.
- Reset asserted in any state takes effect on the next edge: the stream aborts without a last entry, and the snapshot contents become don't-care.
- States:
  - IDLE: on frame_start or pending, go to UPD and clear pending.
  - UPD (1 cycle):
    - Latch cfg_* into gen_*.
    - If pause=0, compute a = gen_angle + angle_step in 14-bit signed.
    - If a >= PI_Q8, gen_angle = a - TWO_PI_Q8; if a < -PI_Q8, gen_angle = a + TWO_PI_Q8; otherwise gen_angle = a.
    - |angle_step| must be <= PI_Q8, so one correction always suffices.
    - Load the settle counter with SETTLE_CYCLES-1, then go to SETTLE.
  - SETTLE:
    - Decrement the counter each cycle.
    - At zero, snapshot gen_matrix into a 16x16 register array, set m_index=0, and go to STREAM.
    - gen_matrix is therefore sampled exactly SETTLE_CYCLES cycles after the gen_* inputs change.
  - STREAM:
    - m_valid=1; m_data = snapshot[m_index]; m_last = (m_index==15).
    - m_data, m_index and m_last must be held stable while m_valid=1 and m_ready=0 (AXI-style rules).
    - On valid&ready: if m_index<15, increment m_index; otherwise deassert m_valid and go to DONE.
    - Entries are registered outputs. With m_ready held high, the 16 entries occupy 16 consecutive cycles.
  - DONE (1 cycle): frame_done=1, then go to IDLE.
- Latency: frame_start in IDLE gives first m_valid 2+SETTLE_CYCLES cycles later. Default is 5.
- frame_start handling outside IDLE:
  - In any non-IDLE state, set pending. If pending is already set, also set overrun.
  - frame_start in the same cycle that DONE moves to IDLE is captured as pending, so it is not lost.
- A pending request starts the next frame from IDLE one cycle later. Frames never overlap.
- Generator overflow handling belongs to the datapath. This block does not inspect overflow.

Decomposition:
- Package model_seq_pkg holds:
  - state enum {IDLE, UPD, SETTLE, STREAM, DONE};
  - PI/TWO_PI/ONE_Q8 constants;
  - a mat4_q8_t typedef for the 16x16 packed matrix.
- Sub-module angle_wrap_q8 is the combinational angle + step wrap. It is reusable for other rotation axes and unit-testable alone.

Test Plan:
- Reset, then one frame_start with cfg_scale=0x0100, angle_step=0, m_ready=1, generator returning identity:
  - m_valid rises 5 cycles after the pulse;
  - data sequence 0100,0,0,0,0,0100,... with entry 15 = 0100;
  - m_last and m_index=15 on the 16th beat;
  - frame_done one cycle later.
- Wrap check: gen_angle=0x0300, angle_step=0x0030 -> next gen_angle = 0x0330 - 0x0648 = 13'h1CE8 (-0x318). Negative step -0x0030 from -0x0300 -> +0x0318.
- pause=1 with angle_step=0x0010 over 3 frames: gen_angle unchanged; cfg_x change 0x0200 -> 0x0300 appears on gen_x in each UPD.
- Backpressure: m_ready toggling 1,0,0,1 pattern:
  - no entry dropped or duplicated;
  - m_data/m_index stable during stalls;
  - 16 accepts total, in index order 0..15.
- Two frame_start pulses during STREAM: pending set; overrun=1 sticky; exactly one extra frame follows.
- Reset asserted at beat 7 of STREAM: next cycle m_valid=0, gen_angle=0, busy=0; no frame_done.

Source files
------------

// File: rtl/model_matrix_sequencer_pkg.sv
// ============================================================================
// Module   : model_seq_pkg
// Purpose  : Shared types and Q-format constants for the model-matrix sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

package model_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UPD    = 3'd1,
        SETTLE = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    localparam logic signed [12:0] PI_Q8_DEF     = 13'sh0324;
    localparam logic signed [12:0] TWO_PI_Q8_DEF = 13'sh0648;
    localparam logic        [15:0] ONE_Q8        = 16'h0100;

    // Entry k holds row k/4, column k%4 in Q8.8.
    typedef logic [15:0][15:0] mat4_q8_t;

endpackage

`default_nettype wire

// File: rtl/model_matrix_sequencer_if.sv
// ============================================================================
// Module   : model_matrix_sequencer_if
// Purpose  : Valid/ready stream carrying the 16 matrix entries downstream
// Revision : 1.0
// ============================================================================
`default_nettype none

interface model_matrix_sequencer_if;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [3:0]  m_index;
    logic        m_last;

    modport master (output m_valid, m_data, m_index, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_index, m_last, output m_ready);
endinterface

`default_nettype wire

// File: rtl/model_matrix_sequencer_angle_wrap.sv
// ============================================================================
// Module   : angle_wrap_q8
// Purpose  : Combinational Q5.8 angle + step, wrapped back into [-pi, pi)
// Revision : 1.0
// ============================================================================
`default_nettype none

module angle_wrap_q8 #(
    parameter logic signed [12:0] PI_Q8     = 13'sh0324,
    parameter logic signed [12:0] TWO_PI_Q8 = 13'sh0648
) (
    input  wire logic signed [12:0] angle,
    input  wire logic signed [12:0] step,
    output logic signed [12:0]      wrapped
);

    localparam logic signed [13:0] PI_W     = 14'(PI_Q8);
    localparam logic signed [13:0] TWO_PI_W = 14'(TWO_PI_Q8);

    logic signed [13:0] sum;
    logic signed [13:0] adj;

    // |step| <= pi keeps the sum within one period of the range.
    always_comb begin
        sum = 14'(angle) + 14'(step);
        adj = sum;
        if (sum >= PI_W) begin
            adj = sum - TWO_PI_W;
        end else if (sum < -PI_W) begin
            adj = sum + TWO_PI_W;
        end
        wrapped = adj[12:0];
    end

endmodule

`default_nettype wire

// File: rtl/model_matrix_sequencer.sv
// ============================================================================
// Module   : model_matrix_sequencer
// Purpose  : Per-frame angle update, generator drive, settle, snapshot, stream
// Revision : 1.0
// ============================================================================
`default_nettype none

module model_matrix_sequencer
    import model_seq_pkg::*;
#(
    parameter int                 SETTLE_CYCLES = 3,
    parameter logic signed [12:0] PI_Q8         = PI_Q8_DEF,
    parameter logic signed [12:0] TWO_PI_Q8     = TWO_PI_Q8_DEF
) (
    input  wire logic        Clk,
    input  wire logic        Reset,
    input  wire logic        frame_start,
    input  wire logic        pause,
    input  wire logic [12:0] angle_step,
    input  wire logic [15:0] cfg_scale,
    input  wire logic [15:0] cfg_x,
    input  wire logic [15:0] cfg_y,
    input  wire logic [15:0] cfg_z,
    output logic [12:0]      gen_angle,
    output logic [15:0]      gen_scale,
    output logic [15:0]      gen_x,
    output logic [15:0]      gen_y,
    output logic [15:0]      gen_z,
    input  wire mat4_q8_t    gen_matrix,
    model_matrix_sequencer_if.master m,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);

    seq_state_t  state_q, state_d;
    logic [12:0] gen_angle_q, gen_angle_d;
    logic [15:0] gen_scale_q, gen_scale_d;
    logic [15:0] gen_x_q, gen_x_d, gen_y_q, gen_y_d, gen_z_q, gen_z_d;
    logic [3:0]  cnt_q, cnt_d;
    mat4_q8_t    snap_q, snap_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] data_q, data_d;
    logic        valid_q, valid_d, last_q, last_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic        overrun_q, overrun_d, pending_q, pending_d;
    logic signed [12:0] angle_next;

    angle_wrap_q8 #(
        .PI_Q8     (PI_Q8),
        .TWO_PI_Q8 (TWO_PI_Q8)
    ) u_wrap (
        .angle   (gen_angle_q),
        .step    (angle_step),
        .wrapped (angle_next)
    );

    always_comb begin
        state_d     = state_q;
        gen_angle_d = gen_angle_q;
        gen_scale_d = gen_scale_q;
        gen_x_d     = gen_x_q;
        gen_y_d     = gen_y_q;
        gen_z_d     = gen_z_q;
        cnt_d       = cnt_q;
        snap_d      = snap_q;
        idx_d       = idx_q;
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;
        pending_d   = pending_q;

        // Requests outside IDLE (including the DONE->IDLE cycle) are queued, one deep.
        if (frame_start && (state_q != IDLE)) begin
            pending_d = 1'b1;
            if (pending_q) begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (frame_start || pending_q) begin
                    state_d   = UPD;
                    pending_d = 1'b0;
                end
            end
            UPD: begin
                gen_scale_d = cfg_scale;
                gen_x_d     = cfg_x;
                gen_y_d     = cfg_y;
                gen_z_d     = cfg_z;
                if (!pause) begin
                    gen_angle_d = angle_next;
                end
                cnt_d   = 4'(SETTLE_CYCLES - 1);
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    snap_d  = gen_matrix;
                    idx_d   = 4'd0;
                    data_d  = gen_matrix[0];
                    last_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = STREAM;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STREAM: begin
                if (valid_q && m.m_ready) begin
                    if (idx_q != 4'd15) begin
                        idx_d  = idx_q + 4'd1;
                        data_d = snap_q[idx_q + 4'd1];
                        last_d = (idx_q == 4'd14);
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        idx_d   = 4'd0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            gen_angle_q <= 13'd0;
            gen_scale_q <= ONE_Q8;
            gen_x_q     <= 16'd0;
            gen_y_q     <= 16'd0;
            gen_z_q     <= 16'd0;
            cnt_q       <= 4'd0;
            snap_q      <= '0;
            idx_q       <= 4'd0;
            data_q      <= 16'd0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gen_angle_q <= gen_angle_d;
            gen_scale_q <= gen_scale_d;
            gen_x_q     <= gen_x_d;
            gen_y_q     <= gen_y_d;
            gen_z_q     <= gen_z_d;
            cnt_q       <= cnt_d;
            snap_q      <= snap_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            pending_q   <= pending_d;
        end
    end

    assign gen_angle  = gen_angle_q;
    assign gen_scale  = gen_scale_q;
    assign gen_x      = gen_x_q;
    assign gen_y      = gen_y_q;
    assign gen_z      = gen_z_q;
    assign m.m_valid  = valid_q;
    assign m.m_data   = data_q;
    assign m.m_index  = idx_q;
    assign m.m_last   = last_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_model_matrix_sequencer.sv
// ============================================================================
// Module   : tb_model_matrix_sequencer
// Purpose  : Directed bench with a queue-based expected-stream model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_model_matrix_sequencer;
    import model_seq_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        pause = 1'b0;
    logic [12:0] angle_step = 13'd0;
    logic [15:0] cfg_scale = 16'h0100, cfg_x = 16'h0, cfg_y = 16'h0, cfg_z = 16'h0;
    logic [12:0] gen_angle;
    logic [15:0] gen_scale, gen_x, gen_y, gen_z;
    mat4_q8_t    gen_matrix;
    logic        busy, frame_done, overrun;

    always #5 Clk = ~Clk;

    model_matrix_sequencer_if sif ();

    model_matrix_sequencer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .pause       (pause),
        .angle_step  (angle_step),
        .cfg_scale   (cfg_scale),
        .cfg_x       (cfg_x),
        .cfg_y       (cfg_y),
        .cfg_z       (cfg_z),
        .gen_angle   (gen_angle),
        .gen_scale   (gen_scale),
        .gen_x       (gen_x),
        .gen_y       (gen_y),
        .gen_z       (gen_z),
        .gen_matrix  (gen_matrix),
        .m           (sif),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    // Generator stub: scale on the diagonal, translation in column 3, angle at (0,1).
    function automatic logic [15:0] gen_entry(int k, logic [12:0] a, logic [15:0] s,
                                              logic [15:0] x, logic [15:0] y, logic [15:0] z);
        if (k == 0 || k == 5 || k == 10) return s;
        if (k == 15) return 16'h0100;
        if (k == 3)  return x;
        if (k == 7)  return y;
        if (k == 11) return z;
        if (k == 1)  return {{3{a[12]}}, a};
        return 16'h0000;
    endfunction

    always_comb begin
        gen_matrix = '0;
        for (int k = 0; k < 16; k++) gen_matrix[k] = gen_entry(k, gen_angle, gen_scale, gen_x, gen_y, gen_z);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: angle accumulator in plain integers plus a queue of expected beats.
    typedef struct { logic [3:0] idx; logic [15:0] data; } beat_t;
    beat_t exp_q[$];
    int    model_angle = 0;

    function automatic int wrap_angle(int a);
        if (a >= 804)  return a - 1608;
        if (a < -804)  return a + 1608;
        return a;
    endfunction

    task automatic push_frame();
        beat_t b;
        if (!pause) model_angle = wrap_angle(model_angle + int'($signed(angle_step)));
        for (int k = 0; k < 16; k++) begin
            b.idx  = 4'(k);
            b.data = gen_entry(k, 13'(model_angle), cfg_scale, cfg_x, cfg_y, cfg_z);
            exp_q.push_back(b);
        end
    endtask

    // Compare process: every accepted beat, stall stability and frame_done timing.
    logic [15:0] log_data [16];
    int          acc_cnt = 0;
    logic        exp_fd = 1'b0, prev_stall = 1'b0;
    logic [15:0] prev_data;
    logic [3:0]  prev_idx;
    logic        prev_last;

    always @(negedge Clk) begin
        beat_t e;
        if (Reset) begin
            exp_fd     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
            exp_fd = 1'b0;
            if (prev_stall) begin
                check("stall_valid", {31'd0, sif.m_valid}, 32'd1);
                check("stall_data", {16'd0, sif.m_data}, {16'd0, prev_data});
                check("stall_index", {28'd0, sif.m_index}, {28'd0, prev_idx});
                check("stall_last", {31'd0, sif.m_last}, {31'd0, prev_last});
            end
            if (sif.m_valid && sif.m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {28'd0, sif.m_index}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", {16'd0, sif.m_data}, {16'd0, e.data});
                    check("beat_index", {28'd0, sif.m_index}, {28'd0, e.idx});
                    check("beat_last", {31'd0, sif.m_last}, {31'd0, (e.idx == 4'd15)});
                    log_data[e.idx] = sif.m_data;
                    acc_cnt++;
                    if (e.idx == 4'd15) exp_fd = 1'b1;
                end
            end
            prev_stall = sif.m_valid && !sif.m_ready;
            prev_data  = sif.m_data;
            prev_idx   = sif.m_index;
            prev_last  = sif.m_last;
        end
    end

    logic       bp_mode = 1'b0;
    logic [3:0] bp_pat = 4'b1001;
    int         bp_cnt = 0;

    initial begin
        sif.m_ready = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            sif.m_ready = bp_mode ? bp_pat[bp_cnt % 4] : 1'b1;
            bp_cnt++;
        end
    end

    task automatic pulse();
        @(posedge Clk); #1 frame_start = 1'b1;
        @(posedge Clk); #1 frame_start = 1'b0;
    endtask

    task automatic wait_drain(int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge Clk);
            if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
        end
        if (!ok) check("drain_timeout", exp_q.size(), 32'd0);
    endtask

    task automatic run_frame(output int lat);
        lat = -1;
        push_frame();
        @(posedge Clk); #1 frame_start = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge Clk); #1 frame_start = 1'b0;
            @(negedge Clk);
            if (sif.m_valid) begin lat = i; break; end
        end
        wait_drain(200);
    endtask

    initial begin
        int  lat;
        bit  found;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_valid", {31'd0, sif.m_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_angle", {19'd0, gen_angle}, 32'd0);
        check("rst_scale", {16'd0, gen_scale}, 32'h0100);
        check("rst_index", {28'd0, sif.m_index}, 32'd0);
        check("rst_data", {16'd0, sif.m_data}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        @(posedge Clk); #1 Reset = 1'b0;

        // Identity frame
        acc_cnt = 0;
        run_frame(lat);
        check("latency", lat, 32'd5);
        check("acc_identity", acc_cnt, 32'd16);
        check("id_e0", {16'd0, log_data[0]}, 32'h0100);
        check("id_e1", {16'd0, log_data[1]}, 32'h0000);
        check("id_e5", {16'd0, log_data[5]}, 32'h0100);
        check("id_e15", {16'd0, log_data[15]}, 32'h0100);

        // Wrap around +pi and -pi
        angle_step = 13'h0300; run_frame(lat);
        check("angle_0300", {19'd0, gen_angle}, 32'h0300);
        angle_step = 13'h0030; run_frame(lat);
        check("angle_wrap_pos", {19'd0, gen_angle}, 32'h1CE8);
        angle_step = 13'h0018; run_frame(lat);
        check("angle_m0300", {19'd0, gen_angle}, 32'h1D00);
        angle_step = 13'h1FD0; run_frame(lat);
        check("angle_wrap_neg", {19'd0, gen_angle}, 32'h0318);

        // Pause keeps the angle but still latches configuration
        pause = 1'b1; angle_step = 13'h0010;
        for (int i = 0; i < 3; i++) begin
            cfg_x = (i % 2 == 1) ? 16'h0300 : 16'h0200;
            run_frame(lat);
            check("pause_angle", {19'd0, gen_angle}, 32'h0318);
            check("pause_gen_x", {16'd0, gen_x}, {16'd0, cfg_x});
        end
        pause = 1'b0; cfg_x = 16'h0000; angle_step = 13'h0000;

        // Backpressure
        bp_mode = 1'b1; acc_cnt = 0;
        run_frame(lat);
        bp_mode = 1'b0;
        check("bp_accepts", acc_cnt, 32'd16);

        // Two extra requests during STREAM: one extra frame plus sticky overrun
        angle_step = 13'h0020;
        push_frame(); push_frame();
        pulse();
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (sif.m_valid) begin found = 1; break; end
        end
        check("ovr_stream_seen", {31'd0, found}, 32'd1);
        pulse();
        repeat (2) @(posedge Clk);
        pulse();
        @(negedge Clk);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        wait_drain(400);
        repeat (10) @(negedge Clk);
        check("overrun_sticky", {31'd0, overrun}, 32'd1);
        check("ovr_idle", {31'd0, busy}, 32'd0);
        check("ovr_angle", {19'd0, gen_angle}, 32'h1D10);
        check("ovr_queue", exp_q.size(), 32'd0);

        // Reset in the middle of a stream
        angle_step = 13'h0000;
        push_frame();
        pulse();
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (sif.m_valid && sif.m_ready && sif.m_index == 4'd7) begin found = 1; break; end
        end
        check("rst_beat7_seen", {31'd0, found}, 32'd1);
        @(posedge Clk); #1 Reset = 1'b1;
        exp_q.delete();
        model_angle = 0;
        @(posedge Clk);
        @(negedge Clk);
        check("abort_valid", {31'd0, sif.m_valid}, 32'd0);
        check("abort_angle", {19'd0, gen_angle}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_overrun", {31'd0, overrun}, 32'd0);
        @(posedge Clk); #1 Reset = 1'b0;
        repeat (10) @(negedge Clk);

        // Recovery frame with new configuration
        cfg_scale = 16'h0200; cfg_y = 16'h0123;
        run_frame(lat);
        check("recover_latency", lat, 32'd5);
        check("recover_scale", {16'd0, gen_scale}, 32'h0200);
        check("recover_e7", {16'd0, log_data[7]}, 32'h0123);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
